mem_lsu: RTL

MEM_LSU -- requirements
Module: mem_lsu

---
 rtl/mem_lsu.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/mem_lsu.sv
// Memory-access stage: splits RV32 loads/stores into BEAT_BYTES-wide beats,
// runs a one-beat-at-a-time request/response handshake, and assembles load results.
module mem_lsu #(
  parameter int BEAT_BYTES = 1,
  parameter int ADDR_W     = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4:0]              wd_i,
  input  logic                    wreg_i,
  input  logic [31:0]             wdata_i,
  input  logic [ADDR_W-1:0]       mem_addr_i,
  input  logic [9:0]              opcode_i,
  input  logic [6:0]              stall_sign,
  output logic [4:0]              wd_o,
  output logic                    wreg_o,
  output logic [31:0]             wdata_o,
  output logic                    mem_stall_request,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [8*BEAT_BYTES-1:0] mem_wdata,
  output logic [BEAT_BYTES-1:0]   mem_wmask,
  input  logic                    mem_rvalid,
  input  logic [8*BEAT_BYTES-1:0] mem_rdata
);

  localparam int LANE_W = 8 * BEAT_BYTES;
  localparam int BB_LOG = $clog2(BEAT_BYTES);
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [2:0]          beat_q, beat_d;
  logic                done_q, done_d;
  logic [31:0]         buf_q, buf_d;
  logic [4:0]          wd_q;
  logic                wreg_q;
  logic [31:0]         wdata_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [LANE_W-1:0]   bwdata_q;
  logic [BEAT_BYTES-1:0] wmask_q;

  logic                freeze;
  logic [2:0]          funct3;
  logic                is_load, is_store, is_mem;
  logic [2:0]          size, nbeats, beat_sel;
  logic [3:0]          beat_span, byte_off;
  logic [31:0]         wshift, load_ext;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [LANE_W-1:0]   wdata_nxt;
  logic [BEAT_BYTES-1:0] mask_nxt;
  logic                load_beat;
  logic                unused_stall;

  assign freeze       = stall_sign[6];
  assign unused_stall = ^stall_sign[5:0];
  assign funct3       = opcode_i[9:7];
  assign is_load      = (opcode_i[6:0] == OP_LOAD);
  assign is_store     = (opcode_i[6:0] == OP_STORE);
  assign is_mem       = is_load | is_store;

  // Request fields are built for the beat about to be issued: beat 0 from IDLE,
  // the following beat when leaving WAIT.
  always_comb begin
    case (funct3[1:0])
      2'b00:   size = 3'd1;
      2'b01:   size = 3'd2;
      default: size = 3'd4;
    endcase
    beat_span = {1'b0, size} + 4'(BEAT_BYTES - 1);
    nbeats    = 3'(beat_span >> BB_LOG);
    beat_sel  = (state_q == S_WAIT) ? beat_q + 3'd1 : 3'd0;
    byte_off  = {1'b0, beat_sel} << BB_LOG;
    addr_nxt  = mem_addr_i + ADDR_W'(byte_off);
    wshift    = wdata_i >> {byte_off, 3'b000};
    wdata_nxt = wshift[LANE_W-1:0];
    for (int j = 0; j < BEAT_BYTES; j++) begin
      mask_nxt[j] = (int'(byte_off) + j) < int'(size);
    end
  end

  always_comb begin
    case (funct3)
      3'b000:  load_ext = {{24{buf_q[7]}}, buf_q[7:0]};
      3'b001:  load_ext = {{16{buf_q[15]}}, buf_q[15:0]};
      3'b100:  load_ext = {24'b0, buf_q[7:0]};
      3'b101:  load_ext = {16'b0, buf_q[15:0]};
      default: load_ext = buf_q;
    endcase
  end

  // NOTE: every always_comb output gets a default before any branch; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    done_d    = done_q;
    buf_d     = buf_q;
    load_beat = 1'b0;
    if (done_q && !freeze) done_d = 1'b0;
    case (state_q)
      S_IDLE: if (is_mem && !done_q && !freeze) begin
        state_d   = S_REQ;
        beat_d    = 3'd0;
        load_beat = 1'b1;
      end
      S_REQ: if (mem_req_ready) state_d = S_WAIT;
      S_WAIT: if (mem_rvalid) begin
        for (int i = 0; i < 4; i++) begin
          if ((i >> BB_LOG) == int'(beat_q) && i < int'(size)) begin
            buf_d[8*i +: 8] = mem_rdata[8*(i % BEAT_BYTES) +: 8];
          end
        end
        if (beat_q == nbeats - 3'd1) begin
          state_d = S_DONE;
        end else begin
          beat_d    = beat_q + 3'd1;
          state_d   = S_REQ;
          load_beat = 1'b1;
        end
      end
      S_DONE: if (!freeze) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      beat_q   <= 3'd0;
      done_q   <= 1'b0;
      buf_q    <= 32'd0;
      wd_q     <= 5'd0;
      wreg_q   <= 1'b0;
      wdata_q  <= 32'd0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      bwdata_q <= '0;
      wmask_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      done_q  <= done_d;
      buf_q   <= buf_d;
      if (load_beat) begin
        we_q     <= is_store;
        addr_q   <= addr_nxt;
        bwdata_q <= wdata_nxt;
        wmask_q  <= mask_nxt;
      end
      if (!freeze) begin
        wd_q   <= wd_i;
        wreg_q <= wreg_i;
        if (!is_mem)                wdata_q <= wdata_i;
        else if (state_q == S_DONE) wdata_q <= is_load ? load_ext : wdata_i;
      end
    end
  end

  assign wd_o              = wd_q;
  assign wreg_o            = wreg_q;
  assign wdata_o           = wdata_q;
  assign mem_stall_request = rst & is_mem & ~done_q;
  assign mem_req_valid     = (state_q == S_REQ);
  assign mem_we            = we_q;
  assign mem_addr          = addr_q;
  assign mem_wdata         = bwdata_q;
  assign mem_wmask         = wmask_q;

endmodule
